bench_stim_misr: RTL and testbench

Synthesizable on-chip counterpart of the benchmark capture bench. The capture bench drives `N` and writes `output_single` to a file. This block drives the DUT's `N` input with a pseudo-random pattern stream, reads back the DUT's single-bit output, and compacts it into a MISR signature. It sits beside a `test_I*_rst` DUT inside the trojan-detection harness, and the signature is handed off with a valid/ready handshake.

---
 rtl/bench_stim_pkg.sv | 22 ++
 rtl/bench_misr.sv | 26 ++
 rtl/bench_stim_misr.sv | 138 +++++++++++++
 tb/tb_bench_stim_misr.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/bench_stim_pkg.sv
// Shared types, default constants and the LFSR step function for the
// on-chip stimulus/MISR bench.
package bench_stim_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } bsm_state_t;

    localparam logic [7:0]  DEF_LFSR_POLY = 8'hB8;
    localparam logic [7:0]  DEF_LFSR_SEED = 8'h01;
    localparam logic [15:0] DEF_MISR_POLY = 16'h1021;

    // Right-shifting Galois step; callers size the result back to their width.
    function automatic logic [31:0] galois_step(input logic [31:0] value,
                                                input logic [31:0] poly);
        return (value >> 1) ^ (value[0] ? poly : 32'd0);
    endfunction

endpackage

// File: rtl/bench_misr.sv
// Left-shifting Galois MISR that folds one response bit per enabled cycle.
module bench_misr #(
    parameter int               SIG_W     = 16,
    parameter logic [SIG_W-1:0] MISR_POLY = 16'h1021
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic             din,
    output logic [SIG_W-1:0] sig
);

    // clr wins over en so a new run always starts from an all-zero signature.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            sig <= '0;
        end else if (clr) begin
            sig <= '0;
        end else if (en) begin
            sig <= ({sig[SIG_W-2:0], 1'b0} ^ (sig[SIG_W-1] ? MISR_POLY : '0))
                   ^ {{(SIG_W-1){1'b0}}, din};
        end
    end

endmodule

// File: rtl/bench_stim_misr.sv
// Drives a DUT's N input with LFSR patterns and compacts its single-bit
// response into a MISR signature offered over a valid/ready handshake.
module bench_stim_misr
    import bench_stim_pkg::*;
#(
    parameter int                N_W       = 3,
    parameter int                LFSR_W    = 8,
    parameter logic [LFSR_W-1:0] LFSR_POLY = DEF_LFSR_POLY,
    parameter logic [LFSR_W-1:0] LFSR_SEED = DEF_LFSR_SEED,
    parameter int                SIG_W     = 16,
    parameter logic [SIG_W-1:0]  MISR_POLY = DEF_MISR_POLY,
    parameter int                CNT_W     = 16,
    parameter int                DUT_LAT   = 1
) (
    input  logic             CK,
    input  logic             reset,
    input  logic             start,
    input  logic [CNT_W-1:0] num_cycles,
    output logic [N_W-1:0]   n_out,
    input  logic             dut_out,
    output logic             busy,
    output logic [SIG_W-1:0] sig,
    output logic             sig_valid,
    input  logic             sig_ready
);

    localparam logic [LFSR_W-1:0] SEED_EFF = (LFSR_SEED == '0) ? LFSR_W'(1) : LFSR_SEED;

    bsm_state_t        state;
    logic [LFSR_W-1:0] lfsr;
    logic [CNT_W-1:0]  count;
    logic              start_acc;
    logic              tag_out;
    logic              tag_any;

    assign start_acc = (state == IDLE) && start;

    // Tag pipe marks which cycles carry a response that belongs to a pattern.
    if (DUT_LAT == 0) begin : g_no_pipe
        assign tag_out = (state == RUN);
        assign tag_any = 1'b0;
    end else begin : g_pipe
        logic [DUT_LAT-1:0] tag_pipe;

        always_ff @(posedge CK or posedge reset) begin
            if (reset) begin
                tag_pipe <= '0;
            end else begin
                tag_pipe[0] <= (state == RUN);
                for (int i = 1; i < DUT_LAT; i++) begin
                    tag_pipe[i] <= tag_pipe[i-1];
                end
            end
        end

        assign tag_out = tag_pipe[DUT_LAT-1];
        assign tag_any = |tag_pipe;
    end

    // n_out is a register, so the seed pattern is loaded straight into it on
    // start and lfsr holds the pattern to present on the following cycle.
    // A zero-length run enters DONE with sig_valid low and raises it one
    // cycle later, keeping the same gap as a drained run.
    always_ff @(posedge CK or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            n_out     <= '0;
            busy      <= 1'b0;
            sig_valid <= 1'b0;
            lfsr      <= SEED_EFF;
            count     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_cycles != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                            count <= num_cycles;
                            n_out <= SEED_EFF[N_W-1:0];
                            lfsr  <= LFSR_W'(galois_step(32'(SEED_EFF), 32'(LFSR_POLY)));
                        end else begin
                            state     <= DONE;
                            sig_valid <= 1'b0;
                        end
                    end
                end
                RUN: begin
                    count <= count - CNT_W'(1);
                    if (count == CNT_W'(1)) begin
                        n_out <= '0;
                        if (DUT_LAT == 0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            sig_valid <= 1'b1;
                        end else begin
                            state <= DRAIN;
                        end
                    end else begin
                        n_out <= lfsr[N_W-1:0];
                        lfsr  <= LFSR_W'(galois_step(32'(lfsr), 32'(LFSR_POLY)));
                    end
                end
                DRAIN: begin
                    if (!tag_any) begin
                        state     <= DONE;
                        busy      <= 1'b0;
                        sig_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (!sig_valid) begin
                        sig_valid <= 1'b1;
                    end else if (sig_ready) begin
                        state     <= IDLE;
                        sig_valid <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    bench_misr #(
        .SIG_W    (SIG_W),
        .MISR_POLY(MISR_POLY)
    ) u_misr (
        .CK   (CK),
        .reset(reset),
        .clr  (start_acc),
        .en   (tag_out),
        .din  (dut_out),
        .sig  (sig)
    );

endmodule

// File: tb/tb_bench_stim_misr.sv
// Self-checking bench: a one-cycle-latency truth-table DUT answers the
// pattern stream and a spec-level model predicts patterns and signatures.
module tb_bench_stim_misr;

    logic        CK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] num_cycles = '0;
    logic [2:0]  n_out;
    logic        dut_out;
    logic        busy;
    logic [15:0] sig;
    logic        sig_valid;
    logic        sig_ready = 1'b0;

    logic [7:0]  truth = 8'h00;
    logic        dut_q = 1'b0;

    int checks = 0;
    int failures = 0;

    always #5 CK = ~CK;

    // Stand-in DUT: registered lookup of the applied pattern.
    always @(posedge CK) dut_q <= truth[n_out];
    assign dut_out = dut_q;

    bench_stim_misr dut (
        .CK        (CK),
        .reset     (reset),
        .start     (start),
        .num_cycles(num_cycles),
        .n_out     (n_out),
        .dut_out   (dut_out),
        .busy      (busy),
        .sig       (sig),
        .sig_valid (sig_valid),
        .sig_ready (sig_ready)
    );

    function automatic int modelPattern(input int idx);
        int v;
        v = 1;
        for (int i = 0; i < idx; i++) begin
            v = (v % 2 == 1) ? ((v / 2) ^ 32'hB8) : (v / 2);
        end
        return v % 8;
    endfunction

    function automatic logic [15:0] modelSig(input int num, input logic [7:0] tbl);
        logic [15:0] m;
        logic        b;
        m = 16'h0000;
        for (int i = 0; i < num; i++) begin
            b = tbl[modelPattern(i)];
            m = {m[14:0], 1'b0} ^ (m[15] ? 16'h1021 : 16'h0000) ^ {15'b0, b};
        end
        return m;
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic stepCycle();
        @(posedge CK);
        #1;
    endtask

    // Pulses start for one edge (e0); returns 1ns after e0.
    task automatic applyStimulus(input int num);
        num_cycles = 16'(num);
        start = 1'b1;
        stepCycle();
        start = 1'b0;
    endtask

    task automatic waitValid(output int cycles);
        cycles = 0;
        while (sig_valid !== 1'b1 && cycles < 300) begin
            stepCycle();
            cycles++;
        end
    endtask

    task automatic handshake();
        sig_ready = 1'b1;
        stepCycle();
        sig_ready = 1'b0;
        checkOutput("valid_drop", 32'(sig_valid), 32'd0);
    endtask

    // Runs num patterns, checking every pattern, busy, the idle n_out,
    // sig_valid latency from e0 and the final signature.
    task automatic runCheck(input string tag, input int num, input logic [7:0] tbl);
        int c;
        truth = tbl;
        applyStimulus(num);
        for (int i = 0; i < num; i++) begin
            checkOutput({tag, "_n_out"}, 32'(n_out), 32'(modelPattern(i)));
            checkOutput({tag, "_busy"}, 32'(busy), 32'd1);
            stepCycle();
        end
        checkOutput({tag, "_n_out_idle"}, 32'(n_out), 32'd0);
        waitValid(c);
        checkOutput({tag, "_latency"}, 32'(num + c), 32'(num + 2));
        checkOutput({tag, "_sig"}, 32'(sig), 32'(modelSig(num, tbl)));
    endtask

    initial begin
        int          c;
        logic [7:0]  rtbl;
        logic [15:0] held;
        int          rnum;

        #12 reset = 1'b0;
        stepCycle();
        checkOutput("rst_n_out", 32'(n_out), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_sig", 32'(sig), 32'd0);
        checkOutput("rst_valid", 32'(sig_valid), 32'd0);

        runCheck("zero50", 50, 8'h00);
        checkOutput("zero50_const", 32'(sig), 32'h0000);
        handshake();

        runCheck("one1", 1, 8'hFF);
        checkOutput("one1_const", 32'(sig), 32'h0001);
        handshake();
        runCheck("one2", 2, 8'hFF);
        checkOutput("one2_const", 32'(sig), 32'h0003);
        handshake();

        // num_cycles = 0: DONE with sig cleared, busy stays low.
        applyStimulus(0);
        checkOutput("n0_busy", 32'(busy), 32'd0);
        checkOutput("n0_valid_early", 32'(sig_valid), 32'd0);
        stepCycle();
        checkOutput("n0_valid", 32'(sig_valid), 32'd1);
        checkOutput("n0_sig", 32'(sig), 32'd0);
        checkOutput("n0_busy2", 32'(busy), 32'd0);
        handshake();

        rtbl = 8'($urandom);
        runCheck("rand20", 20, rtbl);
        handshake();
        rtbl = 8'($urandom);
        rnum = int'($urandom_range(3, 40));
        runCheck("randN", rnum, rtbl);

        // Hold sig_ready low in DONE; a start pulse there must be ignored.
        held = sig;
        for (int k = 0; k < 10; k++) begin
            start = (k == 4);
            num_cycles = 16'd5;
            stepCycle();
            checkOutput("hold_valid", 32'(sig_valid), 32'd1);
            checkOutput("hold_sig", 32'(sig), 32'(held));
            checkOutput("hold_busy", 32'(busy), 32'd0);
        end
        start = 1'b1;
        handshake();
        start = 1'b0;
        checkOutput("handoff_start_ign", 32'(busy), 32'd0);
        stepCycle();
        checkOutput("idle_busy", 32'(busy), 32'd0);
        runCheck("after_hold", 6, rtbl);
        handshake();

        // Asynchronous reset mid-run aborts immediately.
        rtbl = 8'($urandom);
        truth = rtbl;
        applyStimulus(20);
        repeat (6) stepCycle();
        #2 reset = 1'b1;
        #1;
        checkOutput("mid_rst_n_out", 32'(n_out), 32'd0);
        checkOutput("mid_rst_busy", 32'(busy), 32'd0);
        checkOutput("mid_rst_sig", 32'(sig), 32'd0);
        checkOutput("mid_rst_valid", 32'(sig_valid), 32'd0);
        #3 reset = 1'b0;
        stepCycle();
        checkOutput("post_rst_busy", 32'(busy), 32'd0);
        runCheck("post_rst", 20, rtbl);
        handshake();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
